mem_backend: RTL

- Word-organised backing memory that sits directly downstream of the instruction cache and serves its refill (read) and write-back (write) requests.
- Uses a single valid/ready request handshake with a programmable access latency.
- One request is in flight at a time. Read data returns on the same handshake that completes the request.
- Provides a busy flag and read/write transaction counters for bench and performance use.

---
 rtl/mem_backend.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_backend.sv
// mem_backend
//   Word-organised backing memory behind the instruction cache. Serves one
//   refill (read) or write-back (write) request at a time over a valid/ready
//   handshake, with a fixed access latency of LATENCY clock edges from
//   request capture to the completion pulse.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for mem_req_valid; request fields captured on that edge
//   WAIT  | latency down-counter running; inputs ignored
//   RESP  | completion cycle: mem_req_ready high, storage/data already updated
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   mem_req_addr   byte address; word index = addr[DEPTH_LOG2+1:2]
//   mem_req_valid  request present, held stable until ready is seen
//   mem_req_wr     1 = write, 0 = read
//   mem_wr_data    write data
//   mem_req_data   registered read data, changes only on read completion
//   mem_req_ready  one-cycle completion pulse
//   busy           request captured and not yet completed
//   rd_count       completed reads (wrapping)
//   wr_count       completed writes (wrapping)

module mem_backend #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_valid,
  input  logic        mem_req_wr,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_req_data,
  output logic        mem_req_ready,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The counter is loaded with LATENCY-1 on capture and WAIT exits on the
  // edge after it reaches zero, so the ready pulse lands exactly LATENCY
  // edges after capture. With LATENCY = 1 WAIT therefore lasts one cycle.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state_q;
  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [31:0]           wdata_q;

  // Storage starts zeroed and is deliberately outside the reset domain.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  resp_entry;

  // Byte-offset bits and bits above the array size are don't-care
  // (misaligned addresses round down, high addresses alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[31:DEPTH_LOG2+2], mem_req_addr[1:0]};

  assign req_idx    = mem_req_addr[DEPTH_LOG2+1:2];
  assign resp_entry = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      idx_q         <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= 32'd0;
      mem_req_data  <= 32'd0;
      mem_req_ready <= 1'b0;
      busy          <= 1'b0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
    end else begin
      mem_req_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_req_valid) begin
            idx_q   <= req_idx;
            wr_q    <= mem_req_wr;
            wdata_q <= mem_wr_data;
            cnt_q   <= CNT_LOAD;
            busy    <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_entry) begin
            state_q       <= ST_RESP;
            mem_req_ready <= 1'b1;
            busy          <= 1'b0;
            if (wr_q) begin
              wr_count <= wr_count + 16'd1;
            end else begin
              mem_req_data <= mem_q[idx_q];
              rd_count     <= rd_count + 16'd1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write commits on the RESP entry edge. state_q is forced to IDLE while
  // rst is low, so an aborted request can never reach this commit.
  always @(posedge clk) begin
    if (resp_entry && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
